// File: rtl/johnson_sequence_checker.sv
// Johnson-code sequence monitor: decodes the bus, checks successor order, reports lock/wrap/errors.
// Define JOHNSON_CHECKER_BIDIR_EN to also accept predecessors and expose the dir output.
module johnson_sequence_checker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] johnson_in,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [7:0]       err_count
`ifdef JOHNSON_CHECKER_BIDIR_EN
    ,
    output logic             dir
`endif
);

    localparam int N = int'(WIDTH);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(2 * N - 1);
    localparam logic [3:0]       LockCnt = 4'(LOCK_CNT);

    typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [3:0]       match_q, match_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [7:0]       err_count_q, err_count_d;

    // Pattern k: top k ones for k <= N, otherwise only the low 2N-k bits set.
    function automatic logic [WIDTH-1:0] johnson_code(input int k);
        logic [WIDTH-1:0] p;
        for (int b = 0; b < N; b++) begin
            if (k <= N) p[b] = (b >= N - k);
            else        p[b] = (b < 2 * N - k);
        end
        return p;
    endfunction

    logic             dec_legal;
    logic [IDX_W-1:0] dec_idx;
    logic [IDX_W-1:0] succ_idx;
    logic             is_succ;

    always_comb begin
        dec_legal = 1'b0;
        dec_idx   = '0;
        for (int k = 0; k < 2 * N; k++) begin
            if (johnson_in == johnson_code(k)) begin
                dec_legal = 1'b1;
                dec_idx   = IDX_W'(k);
            end
        end
    end

    assign succ_idx = (index_q == LastIdx) ? '0 : index_q + 1'b1;
    assign is_succ  = dec_legal && (dec_idx == succ_idx);

`ifdef JOHNSON_CHECKER_BIDIR_EN
    logic             dir_q, dir_d;
    logic [IDX_W-1:0] pred_idx;
    logic             is_pred;

    assign pred_idx = (index_q == '0) ? LastIdx : index_q - 1'b1;
    assign is_pred  = dec_legal && (dec_idx == pred_idx);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StSearch;
            index_q     <= '0;
            match_q     <= '0;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
            err_count_q <= '0;
`ifdef JOHNSON_CHECKER_BIDIR_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            match_q     <= match_d;
            err_q       <= err_d;
            wrap_q      <= wrap_d;
            err_count_q <= err_count_d;
`ifdef JOHNSON_CHECKER_BIDIR_EN
            dir_q       <= dir_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        match_d     = match_q;
        err_d       = 1'b0;
        wrap_d      = 1'b0;
        err_count_d = err_count_q;
`ifdef JOHNSON_CHECKER_BIDIR_EN
        dir_d       = dir_q;
`endif
        if (sample_en) begin
            case (state_q)
                StSearch: begin
                    if (dec_legal) begin
                        state_d = StVerify;
                        index_d = dec_idx;
                        match_d = '0;
                    end
                end
                StVerify: begin
                    if (!dec_legal) begin
                        state_d = StSearch;
                    end else begin
                        index_d = dec_idx;
                        match_d = '0;
`ifdef JOHNSON_CHECKER_BIDIR_EN
                        if (is_succ || is_pred) begin
                            dir_d = is_succ;
                            // A direction change restarts the run of matches.
                            if (match_q != '0 && is_succ != dir_q) match_d = '0;
                            else                                   match_d = match_q + 4'd1;
                        end
`else
                        if (is_succ) match_d = match_q + 4'd1;
`endif
                        if (match_d == LockCnt) state_d = StLocked;
                    end
                end
                StLocked: begin
`ifdef JOHNSON_CHECKER_BIDIR_EN
                    if (dir_q ? is_succ : is_pred) begin
                        index_d = dec_idx;
                        wrap_d  = dir_q ? (index_q == LastIdx) : (index_q == '0);
                    end else begin
`else
                    if (is_succ) begin
                        index_d = dec_idx;
                        wrap_d  = (index_q == LastIdx);
                    end else begin
`endif
                        err_d = 1'b1;
                        if (err_count_q != 8'hff) err_count_d = err_count_q + 8'd1;
                        if (dec_legal) begin
                            state_d = StVerify;
                            index_d = dec_idx;
                            match_d = '0;
                        end else begin
                            state_d = StSearch;
                        end
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    always_comb begin
        index       = index_q;
        index_valid = (state_q != StSearch);
        locked      = (state_q == StLocked);
        err         = err_q;
        wrap        = wrap_q;
        err_count   = err_count_q;
`ifdef JOHNSON_CHECKER_BIDIR_EN
        dir         = dir_q;
`endif
    end

endmodule
